// File: rtl/audio_pdm_out.sv
// audio_pdm_out -- volume / soft-mute stage followed by a first-order
// sigma-delta (PDM) modulator for the badge speaker pin. A small Wishbone
// register file holds CTRL, VOLUME and a sticky underrun STATUS flag. A
// watchdog forces silence when the filter bank stops delivering samples.
// Build option: define AUDIO_PDM_SOFT_MUTE_EN to ramp the gain one step per
// sample. Otherwise the gain jumps straight to its target.
module audio_pdm_out #(
  parameter int                       AUDIO_BDEPTH  = 12,
  parameter int                       ADDRESS_WIDTH = 16,
  parameter int                       DATA_WIDTH    = 8,
  parameter int                       DATA_BYTES    = DATA_WIDTH / 8,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = 16'h0000,
  parameter int                       CLK_DIV       = 4,
  parameter int                       TIMEOUT       = 4096
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [ADDRESS_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  output logic [DATA_WIDTH-1:0]    dat_o,
  input  logic                     we_i,
  input  logic [DATA_BYTES-1:0]    sel_i,
  input  logic                     stb_i,
  input  logic                     cyc_i,
  output logic                     ack_o,
  input  logic [2:0]               cti_i,
  input  logic [AUDIO_BDEPTH-1:0]  audio_in,
  input  logic                     valid_in,
  output logic                     pdm_o
);

  localparam int B      = AUDIO_BDEPTH;
  localparam int PW     = B + 9;                    // signed product width
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [TICK_W-1:0] TICK_END = TICK_W'(CLK_DIV - 1);

  // Register file and Wishbone handshake
  logic       enable_q, enable_d;
  logic       mute_q, mute_d;
  logic [7:0] volume_q, volume_d;
  logic       status_q, status_d;
  logic       ack_q, ack_d;

  // Datapath state
  logic signed [B-1:0] sample_q, sample_d;
  logic signed [B-1:0] scaled_q, scaled_d;
  logic [7:0]          cur_gain_q, cur_gain_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [B:0]          acc_q, acc_d;
  logic                pdm_q, pdm_d;

  // Combinational helpers
  logic [7:0]           local_adr;
  logic                 in_range;
  logic                 adr_ok;
  logic                 wb_req;
  logic                 wb_wr;
  logic [7:0]           gain_target;
  logic                 underrun;
  logic                 underrun_event;
  logic signed [PW-1:0] sample_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] product;
  logic signed [PW-1:0] shifted;
  logic [B-1:0]         u_val;
  logic [B:0]           acc_sum;
  logic                 tick_wrap;

  assign local_adr = adr_i[7:0];
  assign in_range  = (adr_i[ADDRESS_WIDTH-1:8] == BASE_ADDRESS[ADDRESS_WIDTH-1:8]);
  assign adr_ok    = (local_adr <= 8'h02);
  assign wb_req    = cyc_i & stb_i & in_range & adr_ok;
  assign wb_wr     = wb_req & we_i;

  // Starvation: watchdog saturated, and the edge on which it gets there.
  assign underrun       = (wd_q == WD_MAX);
  assign underrun_event = enable_q & ~valid_in & (wd_q == WD_LAST);

  // A mute/volume write landing with a sample strobe steers that very step.
  assign gain_target = mute_d ? 8'h00 : volume_d;

  // Read mux: only a live, decoded request drives the bus.
  always_comb begin
    dat_o = '0;
    if (wb_req) begin
      case (local_adr)
        8'h00:   begin dat_o[0] = enable_q; dat_o[1] = mute_q; end
        8'h01:   dat_o[7:0] = volume_q;
        8'h02:   dat_o[0] = status_q;
        default: dat_o = '0;
      endcase
    end
  end

  // Register writes, sticky underrun flag (a fresh underrun beats a clear).
  always_comb begin
    enable_d = enable_q;
    mute_d   = mute_q;
    volume_d = volume_q;
    status_d = status_q;
    ack_d    = wb_req;
    if (wb_wr) begin
      case (local_adr)
        8'h00:   begin enable_d = dat_i[0]; mute_d = dat_i[1]; end
        8'h01:   volume_d = dat_i[7:0];
        8'h02:   status_d = 1'b0;
        default: ;
      endcase
    end
    if (underrun_event) begin
      status_d = 1'b1;
    end
  end

  // Gain tracking: step (or jump) toward the target on every sample strobe.
  always_comb begin
    cur_gain_d = cur_gain_q;
    if (!enable_q) begin
      cur_gain_d = 8'h00;
    end else if (valid_in) begin
`ifdef AUDIO_PDM_SOFT_MUTE_EN
      if (cur_gain_q < gain_target) begin
        cur_gain_d = cur_gain_q + 8'd1;
      end else if (cur_gain_q > gain_target) begin
        cur_gain_d = cur_gain_q - 8'd1;
      end
`else
      cur_gain_d = gain_target;
`endif
    end else if (underrun) begin
      cur_gain_d = 8'h00;
    end
  end

  // Sample capture and starvation watchdog.
  always_comb begin
    sample_d = sample_q;
    wd_d     = wd_q;
    if (valid_in) begin
      sample_d = audio_in;
    end
    if (!enable_q || valid_in) begin
      wd_d = '0;
    end else if (!underrun) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Scale by Q1.7 gain, floor-shift by 7, then clamp to the sample range.
  always_comb begin
    sample_ext = {{9{sample_q[B-1]}}, sample_q};
    gain_ext   = {{B{1'b0}}, cur_gain_q, 1'b0} >>> 1;
    product    = sample_ext * gain_ext;
    shifted    = product >>> 7;
    scaled_d   = shifted[B-1:0];
    if (shifted[PW-1:B-1] != {(PW-B+1){shifted[B-1]}}) begin
      scaled_d = shifted[PW-1] ? {1'b1, {(B-1){1'b0}}} : {1'b0, {(B-1){1'b1}}};
    end
  end

  // Offset-binary sample for the modulator; midscale while starved.
  always_comb begin
    u_val = {~scaled_q[B-1], scaled_q[B-2:0]};
    if (underrun) begin
      u_val = {1'b1, {(B-1){1'b0}}};
    end
  end

  // Tick divider and first-order sigma-delta accumulator.
  always_comb begin
    tick_wrap = (tick_q == TICK_END);
    acc_sum   = {1'b0, acc_q[B-1:0]} + {1'b0, u_val};
    tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
    acc_d     = acc_q;
    pdm_d     = pdm_q;
    if (!enable_q) begin
      tick_d = '0;
      acc_d  = '0;
      pdm_d  = 1'b0;
    end else if (tick_wrap) begin
      acc_d = acc_sum;
      pdm_d = acc_sum[B];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      enable_q   <= 1'b1;
      mute_q     <= 1'b0;
      volume_q   <= 8'h80;
      status_q   <= 1'b0;
      ack_q      <= 1'b0;
      sample_q   <= '0;
      scaled_q   <= '0;
      cur_gain_q <= 8'h00;
      wd_q       <= '0;
      tick_q     <= '0;
      acc_q      <= '0;
      pdm_q      <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      mute_q     <= mute_d;
      volume_q   <= volume_d;
      status_q   <= status_d;
      ack_q      <= ack_d;
      sample_q   <= sample_d;
      scaled_q   <= scaled_d;
      cur_gain_q <= cur_gain_d;
      wd_q       <= wd_d;
      tick_q     <= tick_d;
      acc_q      <= acc_d;
      pdm_q      <= pdm_d;
    end
  end

  assign ack_o = ack_q;
  assign pdm_o = pdm_q;

  // Bus fields this block deliberately ignores, plus the stored carry bit.
  logic unused_inputs;
  assign unused_inputs = ^{sel_i, cti_i, acc_q[B], product[6:0], gain_ext[PW-1]};

endmodule

// File: tb/tb_audio_pdm_out.sv
// tb_audio_pdm_out -- randomized scoreboard bench for audio_pdm_out.
`timescale 1ns/1ps
module tb_audio_pdm_out;
  localparam int B       = 12;
  localparam int CLK_DIV = 4;
  localparam int TIMEOUT = 4096;
`ifdef AUDIO_PDM_SOFT_MUTE_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif
  localparam int SETTLE = SOFT ? 270 : 3;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] adr_i = '0;
  logic [7:0]  dat_i = '0;
  logic [7:0]  dat_o;
  logic        we_i = 1'b0;
  logic [0:0]  sel_i = 1'b1;
  logic        stb_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic        ack_o;
  logic [2:0]  cti_i = 3'b000;
  logic [11:0] audio_in = '0;
  logic        valid_in = 1'b0;
  logic        pdm_o;

  audio_pdm_out dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o),
    .cti_i(cti_i), .audio_in(audio_in), .valid_in(valid_in), .pdm_o(pdm_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference register model
  bit       m_enable = 1'b1;
  bit       m_mute   = 1'b0;
  bit [7:0] m_vol    = 8'h80;
  bit       m_status = 1'b0;

  // Scoreboards
  typedef struct { bit is_read; bit exp_ack; logic [7:0] exp_data; logic [15:0] adr; } wb_exp_t;
  typedef struct { int u; int w; int tol; } win_t;
  wb_exp_t wb_q[$];
  win_t    win_q[$];
  string   win_name_q[$];
  int      win_done = 0;

  // Sample feeder state
  bit          feed_en = 1'b0;
  logic [11:0] feed_sample = '0;
  int          gap_lo = 8, gap_hi = 8;
  int          gap_cnt = 0;
  int          strobe_cnt = 0;

  // Expected offset-binary modulator input for a settled sample and gain.
  function automatic int exp_u(input logic [11:0] smp, input int g);
    int s, p, sc;
    s  = $signed(smp);
    p  = s * g;
    sc = p >>> 7;
    if (sc > 2047) sc = 2047;
    if (sc < -2048) sc = -2048;
    return sc + 2048;
  endfunction

  // Sample feeder: one-cycle strobes with random spacing in [gap_lo, gap_hi].
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      valid_in = 1'b0;
      if (feed_en) begin
        if (gap_cnt == 0) begin
          valid_in   = 1'b1;
          audio_in   = feed_sample;
          strobe_cnt = strobe_cnt + 1;
          gap_cnt    = $urandom_range(gap_hi, gap_lo) - 1;
        end else begin
          gap_cnt = gap_cnt - 1;
        end
      end
    end
  end

  // Wishbone monitor: pops one expectation per request the DUT sees.
  initial begin
    wb_exp_t     e;
    logic [7:0]  cap;
    forever begin
      @(negedge clk_i);
      if (cyc_i && stb_i) begin
        cap = dat_o;
        if (wb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL wb_unexpected_request adr=%h", adr_i);
        end else begin
          e = wb_q.pop_front();
          @(negedge clk_i);
          n_checks++;
          if (ack_o !== e.exp_ack) begin
            n_fail++;
            $display("FAIL wb_ack adr=%h got=%b want=%b", e.adr, ack_o, e.exp_ack);
          end
          if (e.is_read) begin
            n_checks++;
            if (cap !== e.exp_data) begin
              n_fail++;
              $display("FAIL wb_read adr=%h got=%h want=%h", e.adr, cap, e.exp_data);
            end
          end
          $display("wb %s adr=%h ack=%b dat=%h", e.is_read ? "rd" : "wr", e.adr, ack_o, cap);
        end
      end
    end
  end

  // PDM monitor: counts high cycles over a requested window.
  initial begin
    win_t    w;
    string   nm;
    longint  high, err;
    forever begin
      @(negedge clk_i);
      if (win_q.size() > 0) begin
        w  = win_q.pop_front();
        nm = win_name_q.pop_front();
        high = 0;
        for (int i = 0; i < w.w; i++) begin
          if (pdm_o === 1'b1) high++;
          if (i < w.w - 1) @(negedge clk_i);
        end
        err = high * 4096 - longint'(w.u) * w.w;
        if (err < 0) err = -err;
        n_checks++;
        if (err > longint'(w.tol) * 4096) begin
          n_fail++;
          $display("FAIL pdm_density %s high=%0d of %0d want~%0d", nm, high, w.w,
                   (longint'(w.u) * w.w) / 4096);
        end
        $display("pdm window %s u=%0d high=%0d/%0d", nm, w.u, high, w.w);
        win_done++;
      end
    end
  end

  task automatic wb_xfer(input logic [15:0] adr, input bit we, input logic [7:0] data,
                         input bit exp_ack, input logic [7:0] exp_data);
    wb_exp_t e;
    e.is_read = !we; e.exp_ack = exp_ack; e.exp_data = exp_data; e.adr = adr;
    wb_q.push_back(e);
    adr_i = adr; we_i = we; dat_i = data; cyc_i = 1'b1; stb_i = 1'b1;
    @(posedge clk_i); #1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic reg_write(input logic [15:0] adr, input logic [7:0] data);
    bit ok;
    ok = (adr[15:8] == 8'h00) && (adr[7:0] <= 8'h02);
    if (ok) begin
      case (adr[7:0])
        8'h00:   begin m_enable = data[0]; m_mute = data[1]; end
        8'h01:   m_vol = data;
        default: m_status = 1'b0;
      endcase
    end
    wb_xfer(adr, 1'b1, data, ok, 8'h00);
  endtask

  task automatic reg_read(input logic [15:0] adr);
    bit         ok;
    logic [7:0] exp;
    ok  = (adr[15:8] == 8'h00) && (adr[7:0] <= 8'h02);
    exp = 8'h00;
    if (ok) begin
      case (adr[7:0])
        8'h00:   exp = {6'b0, m_mute, m_enable};
        8'h01:   exp = m_vol;
        default: exp = {7'b0, m_status};
      endcase
    end
    wb_xfer(adr, 1'b0, 8'h00, ok, exp);
  endtask

  task automatic wait_strobes(input int n);
    int start;
    start = strobe_cnt;
    for (int i = 0; i < n * 14 + 50 && (strobe_cnt - start) < n; i++) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic measure(input int u, input int w, input int tol, input string nm);
    int   start;
    win_t x;
    x.u = u; x.w = w; x.tol = tol;
    start = win_done;
    win_name_q.push_back(nm);
    win_q.push_back(x);
    for (int i = 0; i < w + 20 && win_done == start; i++) @(posedge clk_i);
    #1;
    if (win_done == start) begin
      n_checks++; n_fail++;
      $display("FAIL pdm_window_timeout %s got=pending want=done", nm);
    end
  endtask

  task automatic check_bit(input string nm, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int          ones, prev, cur, alt_ok, steps, found, vol, g;
    bit          mute;
    logic [11:0] smp;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_bit("reset_pdm", pdm_o, 1'b0);
    check_bit("reset_ack", ack_o, 1'b0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    wait_cycles(2);
    reg_read(16'h0000);
    reg_read(16'h0001);
    reg_read(16'h0002);

    // Silence input: midscale gives a strict 0101... bitstream
    feed_sample = 12'h000; gap_lo = 8; gap_hi = 8; feed_en = 1'b1;
    wait_strobes(140);
    ones = 0; alt_ok = 1; prev = -1;
    for (int i = 0; i < 64; i++) begin
      repeat (CLK_DIV) @(negedge clk_i);
      cur = pdm_o;
      if (cur == 1) ones++;
      if (prev == cur) alt_ok = 0;
      prev = cur;
    end
    @(posedge clk_i); #1;
    check_int("silence_ones_64", ones, 32);
    check_int("silence_alternating", alt_ok, 1);

    // Mute ramp length from unity
    check_int("gain_unity_before_mute", int'(dut.cur_gain_q), 128);
    feed_en = 1'b0;
    wait_cycles(12);
    reg_write(16'h0000, 8'h03);
    steps = strobe_cnt; found = 0;
    feed_en = 1'b1;
    for (int i = 0; i < 4000 && found == 0; i++) begin
      @(negedge clk_i);
      if (dut.cur_gain_q == 8'h00) found = 1;
    end
    steps = found ? (strobe_cnt - steps) : -1;
    @(posedge clk_i); #1;
    check_int("mute_ramp_strobes", steps, SOFT ? 128 : 1);
    reg_write(16'h0000, 8'h01);
    gap_lo = 2; gap_hi = 8;

    // VOLUME 0x40 at 0x400: u = 0xA00 over 4096 ticks
    reg_write(16'h0001, 8'h40);
    feed_sample = 12'h400;
    wait_strobes(SETTLE);
    measure(exp_u(12'h400, 8'h40), 4096 * CLK_DIV, 3 * CLK_DIV, "vol40_s400");

    // Saturation at both rails
    reg_write(16'h0001, 8'hFF);
    feed_sample = 12'h800;
    wait_strobes(SETTLE);
    measure(exp_u(12'h800, 8'hFF), 1024, 3 * CLK_DIV, "sat_low");
    feed_sample = 12'h7FF;
    wait_strobes(SETTLE);
    measure(exp_u(12'h7FF, 8'hFF), 1024, 3 * CLK_DIV, "sat_high");

    // One-cycle reset in the middle of a busy stream
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_bit("midstream_reset_pdm", pdm_o, 1'b0);
    @(posedge clk_i); #1;
    m_enable = 1'b1; m_mute = 1'b0; m_vol = 8'h80; m_status = 1'b0;
    reg_read(16'h0000);
    reg_read(16'h0001);
    reg_read(16'h0002);

    // Random volume / mute / sample phases
    for (int k = 0; k < 6; k++) begin
      vol  = $urandom_range(255, 0);
      smp  = 12'($urandom);
      mute = ($urandom_range(7, 0) == 0);
      feed_sample = smp;
      reg_write(16'h0001, 8'(vol));
      reg_write(16'h0000, {6'b0, mute, 1'b1});
      reg_read(16'h0001);
      reg_read(16'h0000);
      wait_strobes(SETTLE);
      g = mute ? 0 : vol;
      measure(exp_u(smp, g), 2048, 3 * CLK_DIV, $sformatf("rand%0d_v%0d_s%0d", k, g, int'(smp)));
    end

    // Starvation: sticky flag, midscale output, forced zero gain
    reg_write(16'h0000, 8'h01);
    reg_write(16'h0001, 8'h80);
    feed_sample = 12'h500;
    wait_strobes(SETTLE);
    reg_read(16'h0002);
    feed_en = 1'b0;
    wait_cycles(TIMEOUT + 20);
    m_status = 1'b1;
    reg_read(16'h0002);
    measure(2048, 1024, 3 * CLK_DIV, "underrun_mid");
    check_int("underrun_gain", int'(dut.cur_gain_q), 0);
    reg_write(16'h0002, 8'h5A);
    reg_read(16'h0002);
    reg_read(16'h0003);
    reg_read(16'h0100);
    reg_write(16'h0003, 8'hFF);
    feed_en = 1'b1;
    wait_strobes(SETTLE);
    measure(exp_u(12'h500, 8'h80), 2048, 3 * CLK_DIV, "resume_after_underrun");

    // Disabled: silent output, no underrun reported while starved
    reg_write(16'h0000, 8'h00);
    feed_en = 1'b0;
    wait_cycles(TIMEOUT + 50);
    reg_read(16'h0002);
    reg_read(16'h0000);
    measure(0, 512, 0, "disabled");
    check_int("disabled_gain", int'(dut.cur_gain_q), 0);
    reg_write(16'h0000, 8'h01);

    wait_cycles(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
